fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the 16-bit RISC core, sitting directly upstream of `instr_mem` and feeding the decode stage. It owns the program counter, drives the byte address into `instr_mem`, captures the returned 16-bit word together with its PC in a small instruction queue, and hands instructions downstream over a valid/ready handshake. Taken branches and jumps from execute arrive as a redirect that flushes the queue and reloads the PC.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC loaded on reset; bit 0 ignored (forced 0).
- `DEPTH`, 2: instruction queue entries; power of two, 2..8.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  16  byte address to `instr_mem` `pc`; equals registered PC, bit 0 always 0.
- `imem_instr`  in  16  word returned combinationally by `instr_mem` for `imem_addr` in the same cycle.
- `halt`  in  1  level; while high no new fetches, PC holds.
- `redirect_valid`  in  1  one-cycle pulse from execute: branch/jump taken.
- `redirect_pc`  in  16  target byte address; bit 0 ignored.
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_instr`  out  16  instruction at queue head.
- `out_pc`  out  16  byte address of `out_instr`.
- `empty`  out  1  queue count == 0.

## Operation
- State: `pc_q` (16 b), circular queue of `DEPTH` entries of {pc, instr}, read/write pointers, `count` (0..DEPTH).
- `pop` = `out_valid & out_ready`. `out_valid` = (`count != 0`) & ~`redirect_valid` (head suppressed during the redirect cycle; downstream must never see a pop in that cycle).
- `space` = (`count < DEPTH`) | `pop`.
- `push` = ~`halt` & ~`redirect_valid` & `space`. On push: write {`pc_q`, `imem_instr`} at write pointer; `pc_q` <= `pc_q` + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- Simultaneous `push` and `pop` at `count == DEPTH`: both occur, count unchanged.
- Redirect (highest priority, regardless of `halt`, `count`, `out_ready`): queue flushed (count, pointers to 0), `pc_q` <= {`redirect_pc[15:1]`, 1'b0}, no push, no pop.
- Halt: no push, `pc_q` holds; queue drains normally via pop. On `halt` deassertion fetch resumes at held `pc_q` with no lost or duplicated instruction.
- Queue full and no pop: `pc_q` holds, `imem_addr` stable, no overwrite.
- `out_instr`/`out_pc` are don't-care when `out_valid` is low but must hold stable (no change) while `out_valid` high and `out_ready` low.
- Count never exceeds `DEPTH` or underflows; pop from empty impossible by construction.

## Timing
- Reset (async assert, sync-style release on next edge): `pc_q` = `RESET_PC & 16'hFFFE`, `count` = 0, pointers 0; hence `imem_addr` = reset PC, `out_valid` = 0, `empty` = 1, `out_instr` = 16'h0000, `out_pc` = 16'h0000.
- Reset asserted mid-operation: all in-flight queue contents discarded immediately; no partial state survives.
- Fetch-to-decode latency: word at `imem_addr` in cycle N appears at `out_instr` with `out_valid` high in cycle N+1 (queue empty case).
- Throughput: 1 instruction/cycle with `out_ready` held high and `halt` low.
- Redirect in cycle N: `imem_addr` = target in N+1, first target instruction valid at output in N+2; redirect penalty 2 cycles with no stale instruction emitted.
- `halt` rising in cycle N: last push in N-1. `halt` falling in N: push in N.

## Test plan
- Reset, `RESET_PC`=16'h0010, `out_ready`=1, imem holds word = address: `out_pc` sequence 0x0010, 0x0012, 0x0014… one per cycle from cycle 1, `out_instr` matching, `out_valid` continuous.
- `out_ready`=0 for 5 cycles after reset (DEPTH=2): `count` reaches 2, `imem_addr` freezes at RESET_PC+4, head stays RESET_PC; release `out_ready` -> next outputs RESET_PC, +2, +4 with no gap or duplicate.
- Redirect to 16'h0101 while queue full and `out_ready`=1: `out_valid`=0 that cycle, `imem_addr`=0x0100 next cycle, next emitted `out_pc`=0x0100; no old-stream PC ever appears after redirect.
- `halt` high 4 cycles mid-stream with `out_ready`=1: queue drains to `empty`=1, PC holds; on release resumes at held PC, PC sequence contiguous.
- PC wrap: redirect to 16'hFFFC, run freely: `out_pc` = 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- `rst_n` pulsed low asynchronously between edges with count=2: `out_valid` and `empty` change immediately to 0/1, `imem_addr`=RESET_PC; fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses instr_mem, and buffers fetched
// {pc, instr} pairs in a small circular queue that feeds decode over valid/ready.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        empty
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0]    PC_INIT  = RESET_PC & 16'hFFFE;
    localparam logic [PW:0]    CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    logic [15:0]   r_pc;
    logic [15:0]   r_q_pc    [DEPTH];
    logic [15:0]   r_q_instr [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic w_pop;
    logic w_push;
    logic w_space;

    // Head is hidden during a redirect so decode can never consume a stale entry.
    assign out_valid = (r_count != '0) & ~redirect_valid;
    assign w_pop     = out_valid & out_ready;
    assign w_space   = (r_count < CNT_FULL) | w_pop;
    assign w_push    = ~halt & ~redirect_valid & w_space;

    assign imem_addr = r_pc;
    assign empty     = (r_count == '0);
    assign out_instr = r_q_instr[r_rptr];
    assign out_pc    = r_q_pc[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= PC_INIT;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[15:1], 1'b0};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 16'd2;
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first fetch lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= 16'h0000;
                r_q_instr[i] <= 16'h0000;
            end
        end else if (w_push) begin
            r_q_pc[r_wptr]    <= r_pc;
            r_q_instr[r_wptr] <= imem_instr;
        end
    end

endmodule
